// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: stall/bubble generation for F/D/E/M/W, ret drain and halt sequencing.
// Optional PERF_CNT_EN macro builds saturating stall/bubble performance counters.
module pipe_ctrl #(
  parameter int RET_BUBBLES = 3,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_Cnd,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);
  localparam logic [3:0] IRET = 4'h9, IMRMOVQ = 4'h5, IPOPQ = 4'hB, IJXX = 4'h7, RNONE = 4'hF;
  localparam logic [2:0] SAOK = 3'd1;

  typedef enum logic [1:0] {RUN = 2'd0, RET_WAIT = 2'd1, HALT = 2'd2} state_t;

  state_t     r_state;
  logic [2:0] r_ret_cnt;
  logic       w_exc, w_wbad, w_lu, w_mis, w_ret;

  assign w_wbad = (W_stat != SAOK);
  assign w_exc  = (m_stat != SAOK) | w_wbad;
  assign w_lu   = ((E_icode == IMRMOVQ) | (E_icode == IPOPQ)) & (E_dstM != RNONE) &
                  ((E_dstM == d_srcA) | (E_dstM == d_srcB));
  assign w_mis  = (E_icode == IJXX) & ~e_Cnd;
  assign w_ret  = (D_icode == IRET);

  // Outputs are forced low while reset is held so an async reset clears them immediately.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    if (rst_n) begin
      case (r_state)
        RUN: begin
          if (w_exc) begin
            M_bubble = 1'b1;
            W_stall  = w_wbad;
          end else if (w_mis) begin
            D_bubble = 1'b1;
            E_bubble = 1'b1;
          end else if (w_lu) begin
            F_stall  = 1'b1;
            D_stall  = 1'b1;
            E_bubble = 1'b1;
          end else if (w_ret) begin
            F_stall  = 1'b1;
            D_bubble = 1'b1;
          end
        end
        RET_WAIT: begin
          F_stall  = 1'b1;
          D_bubble = 1'b1;
          if (w_exc) begin
            M_bubble = 1'b1;
            W_stall  = w_wbad;
          end
        end
        HALT: begin
          F_stall  = 1'b1;
          D_stall  = 1'b1;
          E_bubble = 1'b1;
          M_bubble = 1'b1;
          W_stall  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= RUN;
      r_ret_cnt <= 3'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_wbad) begin
            r_state <= HALT;
          end else if (!w_exc && !w_mis && !w_lu && w_ret && RET_BUBBLES > 1) begin
            r_state   <= RET_WAIT;
            r_ret_cnt <= 3'(RET_BUBBLES - 1);
          end
        end
        RET_WAIT: begin
          if (w_wbad) begin
            r_state <= HALT;
          end else if (r_ret_cnt == 3'd1) begin
            r_state   <= RUN;
            r_ret_cnt <= 3'd0;
          end else begin
            r_ret_cnt <= r_ret_cnt - 3'd1;
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= RUN;
      endcase
    end
  end

  assign halted     = (r_state == HALT);
  assign ctrl_state = r_state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt, r_bubble_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (r_state != HALT) begin
      if (F_stall && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + 1'b1;
      if ((D_bubble || E_bubble) && r_bubble_cnt != '1)
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
`endif

endmodule
